bias_add_stage: RTL and testbench

Parametrised bias stage that sits between a layer's adder-tree outputs and its requantisation/activation logic. It holds a runtime-loadable bias table of `N_GROUPS × N_adder_tree` signed 18-bit entries and adds the correct per-lane bias to each incoming beat with saturation. It selects the output-channel group with an internal wrapping counter and moves data over a valid/ready handshake. It replaces per-layer hard-wired bias constants with one reusable block per layer.

---
 rtl/bias_add_stage.sv | 127 ++++++++++++
 tb/tb_bias_add_stage.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bias_add_stage.sv
// bias_add_stage: per-lane saturating bias add, runtime-loadable table, wrapping group counter.
// Define BIAS_STAGE_RELU_EN to clamp negative lane results to zero after saturation.
module bias_add_stage #(
  parameter int N_adder_tree = 16,
  parameter int DATA_W       = 18,
  parameter int N_GROUPS     = 8,
  parameter int GRP_W        = $clog2(N_GROUPS),
  parameter int LANE_W       = $clog2(N_adder_tree)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [GRP_W-1:0]               cfg_groups,
  input  logic                           bias_wr_en,
  input  logic [GRP_W-1:0]               bias_wr_group,
  input  logic [LANE_W-1:0]              bias_wr_lane,
  input  logic [DATA_W-1:0]              bias_wr_data,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [N_adder_tree*DATA_W-1:0] in_data,
  input  logic                           in_last,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [N_adder_tree*DATA_W-1:0] out_data,
  output logic [GRP_W-1:0]               out_group,
  output logic                           out_last
);

  localparam int BUS_W = N_adder_tree * DATA_W;
  localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  logic [DATA_W-1:0] bias_q [N_GROUPS][N_adder_tree];
  logic [GRP_W-1:0]  grp_q, grp_d;
  logic              out_valid_q, out_valid_d;
  logic [BUS_W-1:0]  out_data_q;
  logic [GRP_W-1:0]  out_group_q;
  logic              out_last_q;
  logic [BUS_W-1:0]  lane_d;
  logic              accept;
  logic              wr_ok;
  logic              grp_wrap;

  assign in_ready  = !out_valid_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_group = out_group_q;
  assign out_last  = out_last_q;

  // Writes outside the table are dropped rather than aliased onto a real entry.
  assign wr_ok = bias_wr_en && (int'(bias_wr_group) < N_GROUPS)
                 && (int'(bias_wr_lane) < N_adder_tree);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int g = 0; g < N_GROUPS; g++) begin
        for (int k = 0; k < N_adder_tree; k++) begin
          bias_q[g][k] <= '0;
        end
      end
    end else if (wr_ok) begin
      bias_q[bias_wr_group][bias_wr_lane] <= bias_wr_data;
    end
  end

  // >= so a shrunk cfg_groups mid-pass still wraps; the table bound keeps grp indexable.
  assign grp_wrap = in_last || (grp_q >= cfg_groups) || (int'(grp_q) == N_GROUPS - 1);

  always_comb begin
    grp_d = grp_q;
    if (accept) begin
      grp_d = grp_wrap ? '0 : grp_q + GRP_W'(1);
    end
  end

  for (genvar k = 0; k < N_adder_tree; k++) begin : g_lane
    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] sat;
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] bias;

    assign din  = in_data[DATA_W*k +: DATA_W];
    assign bias = bias_q[grp_q][k];
    assign sum  = {din[DATA_W-1], din} + {bias[DATA_W-1], bias};

    always_comb begin
      sat = sum[DATA_W-1:0];
      if (sum[DATA_W] != sum[DATA_W-1]) begin
        sat = sum[DATA_W] ? SAT_MIN : SAT_MAX;
      end
    end

`ifdef BIAS_STAGE_RELU_EN
    assign lane_d[DATA_W*k +: DATA_W] = sat[DATA_W-1] ? '0 : sat;
`else
    assign lane_d[DATA_W*k +: DATA_W] = sat;
`endif
  end

  always_comb begin
    out_valid_d = out_valid_q;
    if (accept) begin
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grp_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_group_q <= '0;
      out_last_q  <= 1'b0;
    end else begin
      grp_q       <= grp_d;
      out_valid_q <= out_valid_d;
      if (accept) begin
        out_data_q  <= lane_d;
        out_group_q <= grp_q;
        out_last_q  <= in_last;
      end
    end
  end

endmodule

// File: tb/tb_bias_add_stage.sv
// tb_bias_add_stage: directed stimulus with a scoreboard queue and an independent output monitor.
module tb_bias_add_stage;
  localparam int NL = 16;
  localparam int DW = 18;
  localparam int GW = 3;
  localparam int LW = 4;
  localparam int BW = NL * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic [GW-1:0] cfg_groups;
  logic          bias_wr_en;
  logic [GW-1:0] bias_wr_group;
  logic [LW-1:0] bias_wr_lane;
  logic [DW-1:0] bias_wr_data;
  logic          in_valid, in_ready, in_last;
  logic [BW-1:0] in_data;
  logic          out_valid, out_ready, out_last;
  logic [BW-1:0] out_data;
  logic [GW-1:0] out_group;

  bias_add_stage dut (
    .clk(clk), .rst(rst), .cfg_groups(cfg_groups),
    .bias_wr_en(bias_wr_en), .bias_wr_group(bias_wr_group),
    .bias_wr_lane(bias_wr_lane), .bias_wr_data(bias_wr_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_group(out_group), .out_last(out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [BW-1:0] data;
    logic [GW-1:0] grp;
    logic          last;
  } exp_t;

  exp_t          sb[$];
  int            pop_cyc[$];
  int            cyc = 0;
  int            n_tests = 0;
  int            n_fail = 0;
  int            bias_m[8][NL];
  int            vin[NL];
  logic [BW-1:0] last_exp;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: clamp to the 18-bit signed range, optional ReLU.
  function automatic logic [BW-1:0] calc(input int g);
    logic [BW-1:0] r;
    int s;
    r = '0;
    for (int k = 0; k < NL; k++) begin
      s = vin[k] + bias_m[g][k];
      if (s > 131071) s = 131071;
      if (s < -131072) s = -131072;
`ifdef BIAS_STAGE_RELU_EN
      if (s < 0) s = 0;
`endif
      r[k*DW +: DW] = s[DW-1:0];
    end
    return r;
  endfunction

  task automatic fill(input int x);
    for (int k = 0; k < NL; k++) vin[k] = x;
  endtask

  task automatic drive_data();
    for (int k = 0; k < NL; k++) in_data[k*DW +: DW] = vin[k][DW-1:0];
  endtask

  task automatic send(input int g, input logic last, input logic wr,
                      input int wg, input int wl, input int wd);
    exp_t e;
    int   n;
    e.data = calc(g);
    e.grp  = g[GW-1:0];
    e.last = last;
    sb.push_back(e);
    last_exp = e.data;
    drive_data();
    in_valid      = 1'b1;
    in_last       = last;
    bias_wr_en    = wr;
    bias_wr_group = wg[GW-1:0];
    bias_wr_lane  = wl[LW-1:0];
    bias_wr_data  = wd[DW-1:0];
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      if (in_ready) break;
      n++;
    end
    if (n >= 100) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
    end
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    in_last    = 1'b0;
    bias_wr_en = 1'b0;
    if (wr) bias_m[wg][wl] = wd;
  endtask

  task automatic wr_bias(input int g, input int l, input int d);
    bias_wr_en    = 1'b1;
    bias_wr_group = g[GW-1:0];
    bias_wr_lane  = l[LW-1:0];
    bias_wr_data  = d[DW-1:0];
    @(posedge clk);
    #1;
    bias_wr_en = 1'b0;
    bias_m[g][l] = d;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d beats still pending, required 0", sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_consecutive(input string name, input int want);
    chk({name, "_count"}, BW'(pop_cyc.size()), BW'(want));
    for (int i = 1; i < pop_cyc.size(); i++) begin
      chk({name, "_gap"}, BW'(pop_cyc[i] - pop_cyc[i-1]), BW'(1));
    end
  endtask

  // Monitor: a transfer happens at the next rising edge when valid and ready are both high.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_output: got data %h group %0d, required no output", out_data, out_group);
        end else begin
          e = sb.pop_front();
          pop_cyc.push_back(cyc);
          chk("out_data", out_data, e.data);
          chk("out_group", BW'(out_group), BW'(e.grp));
          chk("out_last", BW'(out_last), BW'(e.last));
        end
      end
    end
  end

  initial begin
    rst = 1'b1; cfg_groups = 3'd2; bias_wr_en = 1'b0; bias_wr_group = '0;
    bias_wr_lane = '0; bias_wr_data = '0; in_valid = 1'b0; in_last = 1'b0;
    in_data = '0; out_ready = 1'b1;
    for (int g = 0; g < 8; g++) for (int k = 0; k < NL; k++) bias_m[g][k] = 0;
    fill(0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset then idle
    @(negedge clk);
    chk("rst_out_valid", BW'(out_valid), BW'(0));
    chk("rst_in_ready", BW'(in_ready), BW'(1));
    chk("rst_out_data", out_data, '0);
    @(posedge clk); #1;
    fill(100);
    send(0, 1'b1, 1'b0, 0, 0, 0);
    drain();

    // Load and wrap
    for (int g = 0; g < 3; g++) for (int k = 0; k < NL; k++) wr_bias(g, k, 1000*g + k);
    pop_cyc.delete();
    fill(5);
    send(0, 1'b0, 1'b0, 0, 0, 0);
    send(1, 1'b0, 1'b0, 0, 0, 0);
    send(2, 1'b0, 1'b0, 0, 0, 0);
    chk("wrap_g2_lane3", BW'(last_exp[3*DW +: DW]), BW'(18'd2008));
    send(0, 1'b0, 1'b0, 0, 0, 0);
    drain();
    chk_consecutive("wrap_b2b", 4);

    // Saturation at grp 1, plus exact-boundary lanes
    wr_bias(1, 0, 200);
    wr_bias(1, 1, -500);
    fill(0);
    vin[0] = 131000; vin[1] = -131000; vin[2] = 130069; vin[3] = -131072;
    send(1, 1'b1, 1'b0, 0, 0, 0);
    chk("sat_pos_ref", BW'(last_exp[0 +: DW]), BW'(18'h1FFFF));
`ifdef BIAS_STAGE_RELU_EN
    chk("sat_neg_ref", BW'(last_exp[DW +: DW]), BW'(18'h00000));
`else
    chk("sat_neg_ref", BW'(last_exp[DW +: DW]), BW'(18'h20000));
`endif
    drain();

    // Backpressure
    out_ready = 1'b0;
    fill(10);
    send(0, 1'b0, 1'b0, 0, 0, 0);
    fill(20);
    drive_data();
    in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("bp_in_ready", BW'(in_ready), BW'(0));
      chk("bp_out_valid", BW'(out_valid), BW'(1));
      chk("bp_out_stable", out_data, last_exp);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    pop_cyc.delete();
    send(1, 1'b0, 1'b0, 0, 0, 0);
    drain();
    chk_consecutive("bp_release", 2);

    // Write collision, in_last, cfg_groups change
    wr_bias(0, 0, 3);
    fill(1);
    send(2, 1'b0, 1'b0, 0, 0, 0);
    send(0, 1'b0, 1'b1, 0, 0, 7);
    chk("collision_old_bias", BW'(last_exp[0 +: DW]), BW'(18'd4));
    send(1, 1'b1, 1'b0, 0, 0, 0);
    send(0, 1'b0, 1'b0, 0, 0, 0);
    chk("new_bias_lane0", BW'(last_exp[0 +: DW]), BW'(18'd8));
    cfg_groups = 3'd0;
    send(1, 1'b0, 1'b0, 0, 0, 0);
    send(0, 1'b0, 1'b0, 0, 0, 0);
    send(0, 1'b0, 1'b0, 0, 0, 0);
    cfg_groups = 3'd2;
    drain();

    // Mid-operation reset with a held output and an ignored write
    out_ready = 1'b0;
    fill(50);
    send(0, 1'b0, 1'b0, 0, 0, 0);
    rst = 1'b1;
    bias_wr_en = 1'b1; bias_wr_group = 3'd0; bias_wr_lane = 4'd5; bias_wr_data = 18'd999;
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    bias_wr_en = 1'b0;
    out_ready = 1'b1;
    for (int g = 0; g < 8; g++) for (int k = 0; k < NL; k++) bias_m[g][k] = 0;
    @(negedge clk);
    chk("mrst_out_valid", BW'(out_valid), BW'(0));
    chk("mrst_out_data", out_data, '0);
    chk("mrst_out_group", BW'(out_group), BW'(0));
    chk("mrst_out_last", BW'(out_last), BW'(0));
    @(posedge clk); #1;
    fill(100);
    send(0, 1'b0, 1'b0, 0, 0, 0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
